cache_miss_ctrl: RTL and testbench
==================================

# cache_miss_ctrl

Miss/refill controller for the 8-way set-associative data cache. It is the consumer side of the tree pseudo-LRU: it reads the victim way, runs the optional dirty writeback and the line refill over the memory handshake, and commits tag/valid. It then reports the accessed way back to the LRU through its enable/path update port. It sits between the tag/data arrays, the LRU instance of the indexed set, and the memory bus.

## Interface
- ADDR_W, 32, byte address width
- INDEX_W, 7, set index width
- LINE_WORDS, 4, 32-bit words per line (power of two, ≥2); WOFF_W = log2(LINE_WORDS); TAG_W = ADDR_W-INDEX_W-WOFF_W-2
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- lookup_valid  in  1  tag lookup result valid this cycle
- lookup_hit  in  1  lookup hit
- hit_way  in  3  hitting way
- lookup_addr  in  ADDR_W  request address
- victim_dirty  in  1  dirty bit of way lru_replace in the indexed set
- victim_tag  in  TAG_W  tag of way lru_replace in the indexed set
- ready  out  1  high only in IDLE
- done  out  1  one-cycle pulse: request finished (hit or refill)
- lru_replace  in  3  victim way from the LRU
- lru_enable, lru_path  out  1, 3  LRU update strobe and accessed way
- arr_way, arr_word  out  3, WOFF_W  data array way/word select; asynchronous read
- arr_rdata  in  32  data array read data, same cycle
- arr_we, arr_wdata  out  1, 32  data array word write
- tag_we, tag_wdata  out  1, TAG_W  tag write for arr_way; sets valid, clears dirty
- mem_req, mem_we  out  1, 1  memory request and direction
- mem_addr, mem_wdata  out  ADDR_W, 32  memory word address, write data
- mem_rdata, mem_ready  in  32, 1  memory read data; beat completes when mem_req && mem_ready

## Operation
- States: IDLE, WB, REFILL, COMMIT, DONE.
- IDLE, lookup_valid && lookup_hit: next cycle lru_enable=1, lru_path=hit_way, done=1. Remain IDLE.
- IDLE, lookup_valid && !lookup_hit: latch victim=lru_replace, addr, victim_dirty, victim_tag. Reset word counter to 0. Go to WB if dirty (see Configuration), else REFILL.
- WB: mem_req=1, mem_we=1, mem_addr={victim_tag,index,word,2'b00}, arr_way=victim, arr_word=word, mem_wdata=arr_rdata. On each beat, word++. After beat LINE_WORDS-1: clear word, go to REFILL.
- REFILL: mem_req=1, mem_we=0, mem_addr={tag,index,word,2'b00}. On each beat: arr_we=1 (combinational with the beat), arr_wdata=mem_rdata, word++. After the last beat, go to COMMIT.
- COMMIT (1 cycle): tag_we=1, tag_wdata=latched tag, arr_way=victim, lru_enable=1, lru_path=victim. Go to DONE.
- DONE (1 cycle): done=1. Go to IDLE.
- Word counter wraps naturally at LINE_WORDS. Words are always transferred in order 0..LINE_WORDS-1; there is no critical-word-first.
- lookup_valid outside IDLE is ignored; the requester must hold off while ready=0.

## Timing
- Reset values: ready=1 after reset, done=0, lru_enable=0, lru_path=0, arr_we=0, tag_we=0, mem_req=0, mem_we=0, mem_addr=0, word counter=0, state IDLE.
- Hit latency: done and lru_enable 1 cycle after lookup_valid.
- Miss latency with zero-wait memory: 1 + (LINE_WORDS if writeback) + LINE_WORDS + 2 cycles to done.
- mem_req and mem_addr are held stable until mem_ready. mem_req drops in the cycle after the final beat.
- lru_enable is a single posedge-launched cycle. The LRU samples it on the following negedge, so no combinational path exists from lru_enable to lru_replace within the cycle.
- rst mid-operation: return to IDLE next edge and deassert all strobes. No tag_we is issued, so the partly refilled line stays with its old tag/valid (the arrays are reset by the same rst).

## Configuration
- CACHE_WRITEBACK_EN defined: the WB state exists, and dirty victims are written back before refill.
- Not defined: write-through cache. victim_dirty and victim_tag are ignored, the WB state is absent, and a miss always goes IDLE→REFILL. mem_we stays 0 at all times.

## Test plan
- Hit: lookup_valid=1, lookup_hit=1, hit_way=5 → next cycle lru_enable=1, lru_path=5, done=1; mem_req never asserted.
- Clean miss, LINE_WORDS=4, lru_replace=3, mem_ready always 1 → 4 reads at offsets 0x0,0x4,0x8,0xC, 4 arr_we on way 3, then tag_we, then lru_path=3, then done; 7 cycles total.
- Dirty miss with CACHE_WRITEBACK_EN, victim_tag=0x1234 → 4 writes to {0x1234,index} with arr_rdata words 0..3, then the refill as above; done at cycle 11.
- Memory wait states: mem_ready low 3 cycles per beat → mem_addr stable while waiting, exactly 4 arr_we pulses.
- lookup_valid pulsed during REFILL → ignored; ready=0 and no extra done.
- rst asserted on the second refill beat → next cycle IDLE, ready=1, tag_we never asserted; a following hit completes normally.

Source files
------------

// File: rtl/cache_miss_ctrl.sv
// Miss/refill controller for the 8-way set-associative data cache: optional dirty
// writeback, in-order line refill, tag commit and LRU update. Macro: CACHE_WRITEBACK_EN.
module cache_miss_ctrl #(
  parameter  int ADDR_W     = 32,
  parameter  int INDEX_W    = 7,
  parameter  int LINE_WORDS = 4,
  localparam int WOFF_W     = $clog2(LINE_WORDS),
  localparam int TAG_W      = ADDR_W - INDEX_W - WOFF_W - 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lookup_valid,
  input  logic              lookup_hit,
  input  logic [2:0]        hit_way,
  input  logic [ADDR_W-1:0] lookup_addr,
  input  logic              victim_dirty,
  input  logic [TAG_W-1:0]  victim_tag,
  output logic              ready,
  output logic              done,
  input  logic [2:0]        lru_replace,
  output logic              lru_enable,
  output logic [2:0]        lru_path,
  output logic [2:0]        arr_way,
  output logic [WOFF_W-1:0] arr_word,
  input  logic [31:0]       arr_rdata,
  output logic              arr_we,
  output logic [31:0]       arr_wdata,
  output logic              tag_we,
  output logic [TAG_W-1:0]  tag_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);

`ifdef CACHE_WRITEBACK_EN
  typedef enum logic [2:0] {IDLE, WB, REFILL, COMMIT, DONE} state_e;
`else
  typedef enum logic [2:0] {IDLE, REFILL, COMMIT, DONE} state_e;
`endif

  localparam logic [WOFF_W-1:0] LAST_WORD = WOFF_W'(LINE_WORDS - 1);

  state_e                     state_q, state_d;
  logic [WOFF_W-1:0]          word_q, word_d;
  logic [2:0]                 victim_q;
  logic [TAG_W+INDEX_W-1:0]   tagIdx_q;
  logic                       hitPend_q;
  logic [2:0]                 hitWay_q;
  logic                       missStart;
  logic                       hitStart;
`ifdef CACHE_WRITEBACK_EN
  logic [TAG_W-1:0]           victimTag_q;
`endif

  // Byte-offset bits never reach memory; write-through builds never read victim state.
  logic unusedBits;
`ifdef CACHE_WRITEBACK_EN
  assign unusedBits = ^lookup_addr[WOFF_W+1:0];
`else
  assign unusedBits = ^{lookup_addr[WOFF_W+1:0], victim_dirty, victim_tag, arr_rdata};
`endif

  assign hitStart = (state_q == IDLE) && lookup_valid && lookup_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      word_q      <= '0;
      victim_q    <= '0;
      tagIdx_q    <= '0;
      hitPend_q   <= 1'b0;
      hitWay_q    <= '0;
`ifdef CACHE_WRITEBACK_EN
      victimTag_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      hitPend_q <= hitStart;
      if (hitStart) hitWay_q <= hit_way;
      if (missStart) begin
        victim_q    <= lru_replace;
        tagIdx_q    <= lookup_addr[ADDR_W-1:WOFF_W+2];
`ifdef CACHE_WRITEBACK_EN
        victimTag_q <= victim_tag;
`endif
      end
    end
  end

  // A hit is acknowledged one cycle later while the FSM stays in IDLE, so hit
  // strobes come from hitPend_q and COMMIT/DONE override them.
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    missStart  = 1'b0;
    ready      = 1'b0;
    done       = hitPend_q;
    lru_enable = hitPend_q;
    lru_path   = hitPend_q ? hitWay_q : 3'd0;
    arr_way    = 3'd0;
    arr_word   = '0;
    arr_we     = 1'b0;
    arr_wdata  = mem_rdata;
    tag_we     = 1'b0;
    tag_wdata  = tagIdx_q[TAG_W+INDEX_W-1:INDEX_W];
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
`ifdef CACHE_WRITEBACK_EN
    mem_wdata  = arr_rdata;
`else
    mem_wdata  = '0;
`endif

    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (lookup_valid && !lookup_hit) begin
          missStart = 1'b1;
          word_d    = '0;
`ifdef CACHE_WRITEBACK_EN
          state_d   = victim_dirty ? WB : REFILL;
`else
          state_d   = REFILL;
`endif
        end
      end
`ifdef CACHE_WRITEBACK_EN
      WB: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = {victimTag_q, tagIdx_q[INDEX_W-1:0], word_q, 2'b00};
        arr_way  = victim_q;
        arr_word = word_q;
        if (mem_ready) begin
          word_d = word_q + WOFF_W'(1);
          if (word_q == LAST_WORD) state_d = REFILL;
        end
      end
`endif
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {tagIdx_q, word_q, 2'b00};
        arr_way  = victim_q;
        arr_word = word_q;
        if (mem_ready) begin
          arr_we = 1'b1;
          word_d = word_q + WOFF_W'(1);
          if (word_q == LAST_WORD) state_d = COMMIT;
        end
      end
      COMMIT: begin
        tag_we     = 1'b1;
        arr_way    = victim_q;
        lru_enable = 1'b1;
        lru_path   = victim_q;
        state_d    = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Randomized bench for cache_miss_ctrl: each request is checked against the memory
// traffic, array writes, tag/LRU updates and latency a line-level model predicts.
module tb_cache_miss_ctrl;
  localparam int ADDR_W = 32, INDEX_W = 7, LINE_WORDS = 4, WOFF_W = 2, TAG_W = 21;
`ifdef CACHE_WRITEBACK_EN
  localparam bit WB_ON = 1'b1;
`else
  localparam bit WB_ON = 1'b0;
`endif

  logic clk, rst, lookup_valid, lookup_hit, victim_dirty;
  logic [2:0] hit_way, lru_replace, lru_path, arr_way;
  logic [ADDR_W-1:0] lookup_addr, mem_addr;
  logic [TAG_W-1:0] victim_tag, tag_wdata;
  logic ready, done, lru_enable, arr_we, tag_we, mem_req, mem_we, mem_ready;
  logic [WOFF_W-1:0] arr_word;
  logic [31:0] arr_rdata, arr_wdata, mem_wdata, mem_rdata;

  cache_miss_ctrl dut (
    .clk(clk), .rst(rst), .lookup_valid(lookup_valid), .lookup_hit(lookup_hit),
    .hit_way(hit_way), .lookup_addr(lookup_addr), .victim_dirty(victim_dirty),
    .victim_tag(victim_tag), .ready(ready), .done(done), .lru_replace(lru_replace),
    .lru_enable(lru_enable), .lru_path(lru_path), .arr_way(arr_way), .arr_word(arr_word),
    .arr_rdata(arr_rdata), .arr_we(arr_we), .arr_wdata(arr_wdata), .tag_we(tag_we),
    .tag_wdata(tag_wdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memData(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC0DE0000;
  endfunction

  function automatic logic [31:0] arrData(input logic [2:0] w, input logic [1:0] i);
    return 32'hDA7A0000 + 32'(w) * 256 + 32'(i);
  endfunction

  assign arr_rdata = arrData(arr_way, arr_word);
  assign mem_rdata = memData(mem_addr);

  int checkCount = 0;
  int passCount  = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Memory responder: each beat is preceded by waitMax cycles of mem_ready low.
  int waitMax = 0;
  initial begin
    int cnt;
    cnt = 0;
    mem_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!mem_req) begin
        mem_ready = 1'b0;
        cnt = 0;
      end else if (cnt >= waitMax) begin
        mem_ready = 1'b1;
        cnt = 0;
      end else begin
        mem_ready = 1'b0;
        cnt++;
      end
    end
  end

  // Event recorder, sampled mid-cycle.
  int cyc = 0;
  bit bWe[$];
  logic [31:0] bAddr[$], bData[$], aData[$], tagData[$];
  logic [2:0] aWay[$], tagWay[$], lruPath[$];
  logic [1:0] aWord[$];
  int tagCyc[$], lruCyc[$], doneCyc[$];
  int stabErr = 0, readyHighWin = 0, winLo = 0, winHi = -1;
  bit prevWait = 1'b0;
  logic [31:0] prevAddr = '0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (prevWait && (!mem_req || mem_addr !== prevAddr)) stabErr++;
    prevWait = mem_req && !mem_ready;
    prevAddr = mem_addr;
    if (mem_req && mem_ready) begin
      bWe.push_back(mem_we);
      bAddr.push_back(mem_addr);
      bData.push_back(mem_wdata);
    end
    if (arr_we) begin
      aWay.push_back(arr_way);
      aWord.push_back(arr_word);
      aData.push_back(arr_wdata);
    end
    if (tag_we) begin
      tagData.push_back(tag_wdata);
      tagWay.push_back(arr_way);
      tagCyc.push_back(cyc);
    end
    if (lru_enable) begin
      lruPath.push_back(lru_path);
      lruCyc.push_back(cyc);
    end
    if (done) doneCyc.push_back(cyc);
    if (cyc >= winLo && cyc <= winHi && ready) readyHighWin++;
  end

  task automatic clearLog();
    bWe.delete(); bAddr.delete(); bData.delete();
    aWay.delete(); aWord.delete(); aData.delete();
    tagData.delete(); tagWay.delete(); tagCyc.delete();
    lruPath.delete(); lruCyc.delete(); doneCyc.delete();
    stabErr = 0;
    readyHighWin = 0;
  endtask

  // One request, entered and left at posedge+1.
  task automatic applyStimulus(input bit isHit, input logic [31:0] addr, input logic [2:0] hway,
                               input logic [2:0] rep, input bit dirty, input logic [20:0] vtag,
                               input int w, input bit glitch);
    int c0, nb, nwb, doneOff, t;
    logic [31:0] base, wbBase;
    clearLog();
    waitMax = w;
    nwb = (!isHit && WB_ON && dirty) ? LINE_WORDS : 0;
    nb = isHit ? 0 : nwb + LINE_WORDS;
    doneOff = isHit ? 1 : nb * (w + 1) + 2;
    base = addr & ~32'hF;
    wbBase = 32'(vtag) * 2048 + ((addr >> 4) % 128) * 16;
    c0 = cyc + 1;
    winLo = c0 + 1;
    winHi = c0 + doneOff;
    lookup_valid = 1'b1; lookup_hit = isHit; hit_way = hway; lookup_addr = addr;
    lru_replace = rep; victim_dirty = dirty; victim_tag = vtag;
    @(posedge clk); #1;
    lookup_valid = 1'b0;
    lookup_hit = 1'($urandom); hit_way = 3'($urandom); lookup_addr = $urandom;
    lru_replace = 3'($urandom); victim_dirty = 1'($urandom); victim_tag = 21'($urandom);
    t = 0;
    while (doneCyc.size() == 0 && t < 400) begin
      lookup_valid = glitch && (t == 1);
      @(posedge clk); #1;
      t++;
    end
    lookup_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("doneTimeout", 64'(t >= 400), 64'(0));
    checkOutput("doneCount", 64'(doneCyc.size()), 64'(1));
    if (doneCyc.size() > 0) checkOutput("doneLatency", 64'(doneCyc[0] - c0), 64'(doneOff));
    checkOutput("lruCount", 64'(lruCyc.size()), 64'(1));
    if (lruCyc.size() > 0) begin
      checkOutput("lruPath", 64'(lruPath[0]), 64'(isHit ? hway : rep));
      checkOutput("lruCycle", 64'(lruCyc[0] - c0), 64'(isHit ? 1 : doneOff - 1));
    end
    checkOutput("tagCount", 64'(tagCyc.size()), 64'(isHit ? 0 : 1));
    if (!isHit && tagCyc.size() > 0) begin
      checkOutput("tagData", 64'(tagData[0]), 64'(addr >> 11));
      checkOutput("tagWay", 64'(tagWay[0]), 64'(rep));
      checkOutput("tagCycle", 64'(tagCyc[0] - c0), 64'(doneOff - 1));
    end
    checkOutput("beatCount", 64'(bAddr.size()), 64'(nb));
    for (int i = 0; i < bAddr.size() && i < nb; i++) begin
      if (i < nwb) begin
        checkOutput("wbWe", 64'(bWe[i]), 64'(1));
        checkOutput("wbAddr", 64'(bAddr[i]), 64'(wbBase + 4 * i));
        checkOutput("wbData", 64'(bData[i]), 64'(arrData(rep, 2'(i))));
      end else begin
        checkOutput("rdWe", 64'(bWe[i]), 64'(0));
        checkOutput("rdAddr", 64'(bAddr[i]), 64'(base + 4 * (i - nwb)));
      end
    end
    checkOutput("arrWeCount", 64'(aWay.size()), 64'(isHit ? 0 : LINE_WORDS));
    for (int i = 0; i < aWay.size() && !isHit && i < LINE_WORDS; i++) begin
      checkOutput("arrWay", 64'(aWay[i]), 64'(rep));
      checkOutput("arrWord", 64'(aWord[i]), 64'(i));
      checkOutput("arrData", 64'(aData[i]), 64'(memData(base + 4 * i)));
    end
    checkOutput("readyBusy", 64'(readyHighWin), 64'(isHit ? 1 : 0));
    checkOutput("addrStable", 64'(stabErr), 64'(0));
  endtask

  task automatic applyResetMidRefill(input logic [31:0] addr);
    clearLog();
    waitMax = 0;
    lookup_valid = 1'b1; lookup_hit = 1'b0; lookup_addr = addr;
    lru_replace = 3'd6; victim_dirty = 1'b0; victim_tag = '0;
    @(posedge clk); #1;
    lookup_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rstReady", 64'(ready), 64'(1));
    checkOutput("rstMemReq", 64'(mem_req), 64'(0));
    checkOutput("rstArrWe", 64'(arr_we), 64'(0));
    repeat (4) @(posedge clk);
    #1;
    checkOutput("rstTagWe", 64'(tagCyc.size()), 64'(0));
    checkOutput("rstDone", 64'(doneCyc.size()), 64'(0));
  endtask

  initial begin
    rst = 1'b1;
    lookup_valid = 1'b0; lookup_hit = 1'b0; hit_way = '0; lookup_addr = '0;
    victim_dirty = 1'b0; victim_tag = '0; lru_replace = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstReadyInit", 64'(ready), 64'(1));
    checkOutput("rstDoneInit", 64'(done), 64'(0));
    checkOutput("rstLruEn", 64'(lru_enable), 64'(0));
    checkOutput("rstLruPath", 64'(lru_path), 64'(0));
    checkOutput("rstArrWeInit", 64'(arr_we), 64'(0));
    checkOutput("rstTagWeInit", 64'(tag_we), 64'(0));
    checkOutput("rstMemReqInit", 64'(mem_req), 64'(0));
    checkOutput("rstMemWe", 64'(mem_we), 64'(0));
    checkOutput("rstMemAddr", 64'(mem_addr), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    applyStimulus(1'b1, 32'h1000_0040, 3'd5, 3'd0, 1'b0, 21'd0, 0, 1'b0);
    applyStimulus(1'b0, 32'h0ABC_D120, 3'd0, 3'd3, 1'b0, 21'd0, 0, 1'b0);
    applyStimulus(1'b0, 32'h7654_3210, 3'd0, 3'd2, 1'b1, 21'h1234, 0, 1'b0);
    applyStimulus(1'b0, 32'h0000_07F0, 3'd0, 3'd7, 1'b1, 21'h1FFFFF, 3, 1'b0);
    applyStimulus(1'b0, 32'hFFFF_FFFC, 3'd0, 3'd1, 1'b0, 21'd0, 1, 1'b1);
    applyResetMidRefill(32'h2222_3330);
    applyStimulus(1'b1, 32'h3333_0000, 3'd2, 3'd0, 1'b0, 21'd0, 0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      bit isHit;
      isHit = ($urandom_range(0, 2) == 0);
      applyStimulus(isHit, $urandom, 3'($urandom), 3'($urandom), 1'($urandom),
                    21'($urandom), $urandom_range(0, 2), !isHit && 1'($urandom));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
